// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state TAP FSM, instruction register, BYPASS and
// IDCODE data registers, and decode/TDO muxing for externally held user registers.
module jtag_tap_controller #(
  parameter int          IR_WIDTH         = 4,
  parameter logic [31:0] IDCODE_VALUE     = 32'h1000_0001,
  parameter int          IDCODE_OPCODE    = 1,
  parameter int          NUM_USER         = 2,
  parameter int          USER_OPCODE_BASE = 8
) (
  input  logic                tck,
  input  logic                trst,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic [IR_WIDTH-1:0] ir,
  output logic [NUM_USER-1:0] user_sel,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  input  logic [NUM_USER-1:0] user_tdo,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    TLR    = 4'h0,
    RTI    = 4'h1,
    SEL_DR = 4'h2,
    CAP_DR = 4'h3,
    SH_DR  = 4'h4,
    EX1_DR = 4'h5,
    PAU_DR = 4'h6,
    EX2_DR = 4'h7,
    UPD_DR = 4'h8,
    SEL_IR = 4'h9,
    CAP_IR = 4'hA,
    SH_IR  = 4'hB,
    EX1_IR = 4'hC,
    PAU_IR = 4'hD,
    EX2_IR = 4'hE,
    UPD_IR = 4'hF
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(IDCODE_OPCODE);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  tap_state_t          cur_state;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [31:0]         idcode_sr;
  logic                bypass_reg;
  logic                idcode_sel;
  logic                bypass_sel;
  logic                dr_lsb;
  logic                enter_tlr;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      cur_state <= TLR;
    end else begin
      unique case (cur_state)
        TLR:    cur_state <= tms ? TLR    : RTI;
        RTI:    cur_state <= tms ? SEL_DR : RTI;
        SEL_DR: cur_state <= tms ? SEL_IR : CAP_DR;
        CAP_DR: cur_state <= tms ? EX1_DR : SH_DR;
        SH_DR:  cur_state <= tms ? EX1_DR : SH_DR;
        EX1_DR: cur_state <= tms ? UPD_DR : PAU_DR;
        PAU_DR: cur_state <= tms ? EX2_DR : PAU_DR;
        EX2_DR: cur_state <= tms ? UPD_DR : SH_DR;
        UPD_DR: cur_state <= tms ? SEL_DR : RTI;
        SEL_IR: cur_state <= tms ? TLR    : CAP_IR;
        CAP_IR: cur_state <= tms ? EX1_IR : SH_IR;
        SH_IR:  cur_state <= tms ? EX1_IR : SH_IR;
        EX1_IR: cur_state <= tms ? UPD_IR : PAU_IR;
        PAU_IR: cur_state <= tms ? EX2_IR : PAU_IR;
        EX2_IR: cur_state <= tms ? UPD_IR : SH_IR;
        UPD_IR: cur_state <= tms ? SEL_DR : RTI;
      endcase
    end
  end

  assign state      = cur_state;
  assign capture_dr = (cur_state == CAP_DR);
  assign shift_dr   = (cur_state == SH_DR);
  assign update_dr  = (cur_state == UPD_DR);

  // TLR is only reachable from SelIR or TLR itself; forcing ir on entry keeps
  // user_sel from lingering for a cycle after a TMS reset.
  assign enter_tlr = tms && ((cur_state == SEL_IR) || (cur_state == TLR));

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_shift <= IR_CAPTURE;
    end else if (cur_state == CAP_IR) begin
      ir_shift <= IR_CAPTURE;
    end else if (cur_state == SH_IR) begin
      ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir <= IR_IDCODE;
    end else if (enter_tlr || (cur_state == TLR)) begin
      ir <= IR_IDCODE;
    end else if (cur_state == UPD_IR) begin
      ir <= ir_shift;
    end
  end

  assign idcode_sel = (ir == IR_IDCODE);

  for (genvar k = 0; k < NUM_USER; k++) begin : g_user_dec
    assign user_sel[k] = (ir == IR_WIDTH'(USER_OPCODE_BASE + k));
  end

  assign bypass_sel = !idcode_sel && !(|user_sel);

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      idcode_sr <= IDCODE_VALUE;
    end else if (idcode_sel && (cur_state == CAP_DR)) begin
      idcode_sr <= IDCODE_VALUE;
    end else if (idcode_sel && (cur_state == SH_DR)) begin
      idcode_sr <= {tdi, idcode_sr[31:1]};
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      bypass_reg <= 1'b0;
    end else if (bypass_sel && (cur_state == CAP_DR)) begin
      bypass_reg <= 1'b0;
    end else if (bypass_sel && (cur_state == SH_DR)) begin
      bypass_reg <= tdi;
    end
  end

  always_comb begin
    dr_lsb = bypass_reg;
    if (idcode_sel) begin
      dr_lsb = idcode_sr[0];
    end else if (|user_sel) begin
      dr_lsb = |(user_sel & user_tdo);
    end
  end

  // TDO is launched on the falling edge so the probe samples it half a period later.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo_en <= (cur_state == SH_IR) || (cur_state == SH_DR);
      if (cur_state == SH_IR) begin
        tdo <= ir_shift[0];
      end else if (cur_state == SH_DR) begin
        tdo <= dr_lsb;
      end else begin
        tdo <= 1'b0;
      end
    end
  end

endmodule
